riscv_dmem: RTL and testbench

RISCV_DMEM -- requirements
Module: riscv_dmem

---
 rtl/riscv_dmem_if.sv | 23 ++
 rtl/riscv_dmem.sv | 130 +++++++++++++
 tb/tb_riscv_dmem.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_if.sv
// Hart data-port and TX byte-stream signals between the MA stage, riscv_dmem and the TX consumer.
interface riscv_dmem_if #(
   parameter int unsigned XLEN = 32
);
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_data;
   logic            mem_write;
   logic [XLEN-1:0] mem_read;
   logic [7:0]      tx_data;
   logic            tx_valid;
   logic            tx_ready;
   logic            bus_err;

   modport master (
      output mem_addr, mem_data, mem_write, tx_ready,
      input  mem_read, tx_data, tx_valid, bus_err
   );

   modport slave (
      input  mem_addr, mem_data, mem_write, tx_ready,
      output mem_read, tx_data, tx_valid, bus_err
   );
endinterface

// File: rtl/riscv_dmem.sv
// Data memory: word RAM plus memory-mapped TX byte FIFO, FIFO status and a free-running cycle counter.
// Loads are combinational on mem_addr; stores and FIFO push/pop commit on the rising edge.
module riscv_dmem #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic         clk,
   input logic         rst,
   riscv_dmem_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [XLEN-1:0] ADDR_TX     = XLEN'(32'h8000_0000);
   localparam logic [XLEN-1:0] ADDR_STATUS = XLEN'(32'h8000_0004);
   localparam logic [XLEN-1:0] ADDR_CYCLE  = XLEN'(32'h8000_0008);
   localparam logic [CW-1:0]   FIFO_FULL   = CW'(FIFO_DEPTH);

   logic [XLEN-1:0] ram [DEPTH];
   logic [7:0]      fifo [FIFO_DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic            overflow;
   logic            bus_err_q;
   logic [31:0]     cycle_cnt;

   logic [XLEN-1:0] addr_al;
   logic [AW-1:0]   ram_idx;
   logic            aligned;
   logic            sel_ram;
   logic            sel_tx;
   logic            sel_status;
   logic            sel_cycle;
   logic            unmapped;
   logic            fifo_empty;
   logic            fifo_full;
   logic            pop;
   logic            push_req;
   logic            push;
   logic [XLEN-1:0] status_word;

   // Register decode uses the word-aligned address so misaligned loads see the enclosing word.
   always_comb begin
      addr_al    = {bus.mem_addr[XLEN-1:2], 2'b00};
      ram_idx    = bus.mem_addr[AW+1:2];
      aligned    = (bus.mem_addr[1:0] == 2'b00);
      sel_ram    = (bus.mem_addr[XLEN-1:AW+2] == '0);
      sel_tx     = (addr_al == ADDR_TX);
      sel_status = (addr_al == ADDR_STATUS);
      sel_cycle  = (addr_al == ADDR_CYCLE);
      unmapped   = !(sel_ram || sel_tx || sel_status || sel_cycle);
   end

   // A push into a full FIFO is still accepted when the head leaves in the same cycle.
   always_comb begin
      fifo_empty = (count == '0);
      fifo_full  = (count == FIFO_FULL);
      pop        = !fifo_empty && bus.tx_ready;
      push_req   = bus.mem_write && aligned && sel_tx;
      push       = push_req && (!fifo_full || pop);
   end

   always_comb begin
      status_word      = '0;
      status_word[0]   = fifo_empty;
      status_word[1]   = fifo_full;
      status_word[2]   = overflow;
      status_word[6:4] = 3'(count);

      bus.mem_read = '0;
      if (sel_ram) begin
         bus.mem_read = ram[ram_idx];
      end else if (sel_status) begin
         bus.mem_read = status_word;
      end else if (sel_cycle) begin
         bus.mem_read = XLEN'(cycle_cnt);
      end

      bus.tx_valid = !fifo_empty;
      bus.tx_data  = fifo_empty ? 8'h00 : fifo[rd_ptr];
      bus.bus_err  = bus_err_q;
   end

   always_ff @(posedge clk) begin
      if (bus.mem_write && aligned && sel_ram) begin
         ram[ram_idx] <= bus.mem_data;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo[wr_ptr] <= bus.mem_data[7:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         bus_err_q <= 1'b0;
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
         if (push_req && !push) begin
            overflow <= 1'b1;
         end
         if (bus.mem_write && (!aligned || unmapped)) begin
            bus_err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_riscv_dmem.sv
// Scoreboard bench for riscv_dmem: a queue/array reference model predicts every cycle's outputs,
// and a monitor at the falling edge compares them and checks each TX handshake byte in order.
module tb_riscv_dmem;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned DEPTH      = 1024;
   localparam int unsigned FIFO_DEPTH = 4;

   localparam logic [31:0] RAM_END = 32'(DEPTH * 4);
   localparam logic [31:0] TX_A    = 32'h8000_0000;
   localparam logic [31:0] ST_A    = 32'h8000_0004;
   localparam logic [31:0] CY_A    = 32'h8000_0008;

   typedef struct {
      string       name;
      logic [31:0] rd;
      bit          chk_rd;
      logic        tv;
      logic [7:0]  td;
      logic        be;
   } exp_t;

   logic clk;
   logic rst;

   riscv_dmem_if #(.XLEN(XLEN)) bus ();

   riscv_dmem #(
      .XLEN(XLEN),
      .DEPTH(DEPTH),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // reference model state
   logic [31:0] ram_m [int unsigned];
   logic [7:0]  mq[$];
   logic [7:0]  sb_tx[$];
   exp_t        exp_q[$];
   bit          m_ovf;
   bit          m_err;
   logic [31:0] m_cyc;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, got, want);
      end
   endtask

   function automatic void model_read(input logic [31:0] addr, output logic [31:0] v, output bit known);
      logic [31:0] a;
      int          occ;
      a     = addr & 32'hFFFF_FFFC;
      occ   = mq.size();
      known = 1'b1;
      v     = 32'h0;
      if (a < RAM_END) begin
         if (ram_m.exists(a >> 2)) v = ram_m[a >> 2];
         else known = 1'b0;
      end else if (a == ST_A) begin
         v = 32'(occ * 16 + (m_ovf ? 4 : 0) + (occ == FIFO_DEPTH ? 2 : 0) + (occ == 0 ? 1 : 0));
      end else if (a == CY_A) begin
         v = m_cyc;
      end
   endfunction

   // One bus cycle: drive, predict this cycle's outputs, advance the model past the next edge.
   task automatic cyc_op(input logic [31:0] addr, input logic [31:0] data, input logic we,
                         input logic rdy, input string nm);
      exp_t        e;
      bit          pop;
      logic [31:0] a;
      bus.mem_addr  = addr;
      bus.mem_data  = data;
      bus.mem_write = we;
      bus.tx_ready  = rdy;
      e.name = nm;
      model_read(addr, e.rd, e.chk_rd);
      e.tv = (mq.size() != 0);
      e.td = e.tv ? mq[0] : 8'h00;
      e.be = m_err;
      exp_q.push_back(e);

      pop = (mq.size() != 0) && rdy;
      if (pop) void'(mq.pop_front());
      a = addr & 32'hFFFF_FFFC;
      if (we) begin
         if (addr[1:0] != 2'b00) m_err = 1'b1;
         else if (a < RAM_END) ram_m[a >> 2] = data;
         else if (a == TX_A) begin
            if (mq.size() < FIFO_DEPTH) begin
               mq.push_back(data[7:0]);
               sb_tx.push_back(data[7:0]);
            end else begin
               m_ovf = 1'b1;
            end
         end else if (a != ST_A && a != CY_A) m_err = 1'b1;
      end
      m_cyc = m_cyc + 32'd1;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      bus.mem_write = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
      chk("rst_bus_err", 32'(bus.bus_err), 32'h0);
      mq.delete();
      sb_tx.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_err = 1'b0;
      m_cyc = 32'h0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   // monitor
   initial begin
      exp_t       e;
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               if (e.chk_rd) chk({e.name, "_mem_read"}, bus.mem_read, e.rd);
               chk({e.name, "_tx_valid"}, 32'(bus.tx_valid), 32'(e.tv));
               chk({e.name, "_tx_data"}, 32'(bus.tx_data), 32'(e.td));
               chk({e.name, "_bus_err"}, 32'(bus.bus_err), 32'(e.be));
            end
            if (bus.tx_valid && bus.tx_ready) begin
               if (sb_tx.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tx_pop: got byte %h, required no handshake", bus.tx_data);
               end else begin
                  b = sb_tx.pop_front();
                  chk("tx_order", 32'(bus.tx_data), 32'(b));
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] addr;
      logic [31:0] data;
      logic        we;
      int unsigned sel;

      rst           = 1'b1;
      bus.mem_addr  = '0;
      bus.mem_data  = '0;
      bus.mem_write = 1'b0;
      bus.tx_ready  = 1'b0;
      m_cyc         = 32'h0;
      @(posedge clk);
      #2;
      do_reset();

      // cycle counter after reset, reset-state STATUS
      for (int i = 0; i < 11; i++) cyc_op(CY_A, 32'h0, 1'b0, 1'b0, "cycle_count");
      cyc_op(ST_A, 32'h0, 1'b0, 1'b1, "status_reset");

      for (int unsigned w = 0; w < 16; w++) cyc_op(w * 4, $urandom, 1'b1, 1'b0, "ram_init");
      cyc_op(RAM_END - 4, $urandom, 1'b1, 1'b0, "ram_init_top");

      cyc_op(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, "ram_wr");
      cyc_op(32'h10, 32'h0, 1'b0, 1'b0, "ram_rd_10");
      cyc_op(32'h14, 32'h0, 1'b0, 1'b0, "ram_rd_14");
      cyc_op(32'h13, 32'h0, 1'b0, 1'b0, "ram_rd_misaligned");

      for (int unsigned k = 0; k < 5; k++) cyc_op(TX_A, 32'h41 + k, 1'b1, 1'b0, "tx_fill");
      cyc_op(ST_A, 32'h0, 1'b0, 1'b0, "status_full_ovf");
      cyc_op(TX_A, 32'h0, 1'b0, 1'b0, "txdata_read");
      for (int i = 0; i < 5; i++) cyc_op(ST_A, 32'h0, 1'b0, 1'b1, "tx_drain");
      cyc_op(ST_A, 32'h0, 1'b0, 1'b0, "status_drained");

      do_reset();
      for (int unsigned k = 0; k < 4; k++) cyc_op(TX_A, 32'h61 + k, 1'b1, 1'b0, "tx_fill2");
      cyc_op(TX_A, 32'h55, 1'b1, 1'b1, "tx_push_pop_full");
      cyc_op(ST_A, 32'h0, 1'b0, 1'b0, "status_full_no_ovf");
      for (int i = 0; i < 5; i++) cyc_op(ST_A, 32'h0, 1'b0, 1'b1, "tx_drain2");
      cyc_op(TX_A, 32'h77, 1'b1, 1'b1, "tx_push_empty_ready");
      cyc_op(ST_A, 32'h0, 1'b0, 1'b1, "tx_after_empty_push");
      cyc_op(ST_A, 32'h0, 1'b0, 1'b0, "status_after_single");

      cyc_op(ST_A, 32'hFFFF_FFFF, 1'b1, 1'b0, "status_write");
      cyc_op(CY_A, 32'h0, 1'b1, 1'b0, "cycle_write");
      cyc_op(32'h2, 32'h1234_5678, 1'b1, 1'b0, "misaligned_wr");
      cyc_op(32'h0, 32'h0, 1'b0, 1'b0, "ram_rd_0");
      cyc_op(32'h4000_0000, 32'hCAFE_F00D, 1'b1, 1'b0, "unmapped_wr");
      cyc_op(32'h4000_0000, 32'h0, 1'b0, 1'b0, "unmapped_rd");
      cyc_op(RAM_END, 32'h0, 1'b0, 1'b0, "ram_end_rd");

      force dut.cycle_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.cycle_cnt;
      m_cyc = 32'hFFFF_FFFF;
      cyc_op(CY_A, 32'h0, 1'b0, 1'b0, "cycle_max");
      cyc_op(CY_A, 32'h0, 1'b0, 1'b0, "cycle_wrap");

      cyc_op(32'h10, 32'h0BAD_F00D, 1'b1, 1'b0, "ram_wr_pre_rst");
      for (int unsigned k = 0; k < 3; k++) cyc_op(TX_A, 32'h31 + k, 1'b1, 1'b0, "tx_queue3");
      cyc_op(ST_A, 32'h0, 1'b0, 1'b0, "status_3");
      bus.tx_ready = 1'b1;
      do_reset();
      cyc_op(ST_A, 32'h0, 1'b0, 1'b0, "status_post_rst");
      cyc_op(32'h10, 32'h0, 1'b0, 1'b0, "ram_keep_rst");

      for (int n = 0; n < 600; n++) begin
         sel  = $urandom_range(0, 9);
         data = $urandom;
         we   = ($urandom_range(0, 9) < 4);
         if (sel <= 3) begin
            addr = ($urandom_range(0, 16) == 16) ? (RAM_END - 4) : 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 15) == 0) addr = addr + 32'($urandom_range(1, 3));
         end else if (sel <= 5) begin
            addr = TX_A;
            we   = ($urandom_range(0, 9) < 7);
         end else if (sel == 6) addr = ST_A;
         else if (sel == 7) addr = CY_A;
         else if (sel == 8) addr = TX_A + 32'($urandom_range(1, 11));
         else begin
            case ($urandom_range(0, 3))
               0:       addr = RAM_END;
               1:       addr = 32'h8000_000C;
               2:       addr = 32'hFFFF_FFFC;
               default: addr = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
            endcase
            we = ($urandom_range(0, 19) == 0);
         end
         cyc_op(addr, data, we, 1'($urandom_range(0, 1)), "rand");
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      for (int i = 0; i < 8; i++) cyc_op(ST_A, 32'h0, 1'b0, 1'b1, "final_drain");
      cyc_op(ST_A, 32'h0, 1'b0, 1'b0, "final_status");
      @(negedge clk);
      chk("scoreboard_empty", 32'(sb_tx.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
